// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined prefix adder.
//   gp_t        : one (generate, propagate) pair
//   level_span  : distance spanned by Kogge-Stone level k (2^k)
//   num_stages  : register stages for a given width and levels-per-stage
package prefix_adder_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int level_span(input int k);
      return 1 << k;
   endfunction

   function automatic int num_stages(input int width, input int lvl_per_stg);
      int levels;
      levels = $clog2(width);
      return (levels + lvl_per_stg - 1) / lvl_per_stg;
   endfunction

endpackage

// File: rtl/prefix_gp_node.sv
// Combinational Kogge-Stone (G, P) combine.
// Ports:
//   cur  : (g, p) of the current position
//   prev : (g, p) of the position one span below
//   res  : combined (G, P)
module prefix_gp_node
   import prefix_adder_pkg::*;
(
   input  gp_t cur,
   input  gp_t prev,
   output gp_t res
);

   assign res.g = cur.g | (cur.p & prev.g);
   assign res.p = cur.p & prev.p;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// A register stage follows every LVL_PER_STG prefix levels; the sum is
// formed combinationally from the last stage register.
// Parameters: WIDTH (power of two, >= 4), LVL_PER_STG (>= 1)
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid, in_ready   : operand handshake
//   a, b, cin, sub       : operands; sub=1 gives a - b (cin ignored)
//   out_valid, out_ready : result handshake
//   sum, cout            : result and MSB carry (sub: 1 = no borrow)
//   ovf, zero            : signed overflow / zero result, only when
//                          PREFIX_ADDER_FLAGS_EN is defined
module prefix_adder_pipe
   import prefix_adder_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int LVL_PER_STG = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PREFIX_ADDER_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero
`endif
);

   localparam int L = $clog2(WIDTH);
   localparam int S = num_stages(WIDTH, LVL_PER_STG);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p_raw;
   logic             c0;
   gp_t  [WIDTH-1:0] gp_pre;

   logic [S-1:0]     v;
   logic [S-1:0]     adv;
   logic [S-1:0]     load;
   logic [S:0]       free;

   gp_t  [WIDTH-1:0] fin_gp;
   logic [WIDTH-1:0] fin_praw;
   logic             fin_c0;
   logic [WIDTH-1:0] g_fin;
   logic [WIDTH-1:0] p_fin;
   logic             unused_p;
`ifdef PREFIX_ADDER_FLAGS_EN
   logic             fin_a_msb;
   logic             fin_b_msb;
`endif

   assign b_eff = sub ? ~b : b;
   assign c0    = sub | cin;
   assign p_raw = a ^ b_eff;

   // Carry-in enters as the generate of position -1, folded into bit 0.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         gp_pre[i].g = a[i] & b_eff[i];
         gp_pre[i].p = p_raw[i];
      end
      gp_pre[0].g = (a[0] & b_eff[0]) | (p_raw[0] & c0);
   end

   // free[n]: stage n can take a beat this cycle (empty or emptying).
   always_comb begin
      adv     = '0;
      load    = '0;
      free    = '0;
      free[S] = out_ready;
      for (int n = S - 1; n >= 0; n--) begin
         adv[n]  = v[n] & free[n+1];
         free[n] = ~v[n] | adv[n];
      end
      in_ready = free[0];
      load[0]  = in_valid & free[0];
      for (int n = 1; n < S; n++) begin
         load[n] = adv[n-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
      end else begin
         for (int n = 0; n < S; n++) begin
            if (load[n])
               v[n] <= 1'b1;
            else if (adv[n])
               v[n] <= 1'b0;
         end
      end
   end

   for (genvar s = 0; s < S; s++) begin : stg
      localparam int LAST = ((s + 1) * LVL_PER_STG > L) ? L - 1 : (s + 1) * LVL_PER_STG - 1;

      gp_t  [WIDTH-1:0] gp_q;
      logic [WIDTH-1:0] praw_q;
      logic [WIDTH-1:0] praw_d;
      logic             c0_q;
      logic             c0_d;
`ifdef PREFIX_ADDER_FLAGS_EN
      logic             a_msb_q, a_msb_d;
      logic             b_msb_q, b_msb_d;
`endif

      if (s == 0) begin : g_first
         assign praw_d = p_raw;
         assign c0_d   = c0;
`ifdef PREFIX_ADDER_FLAGS_EN
         assign a_msb_d = a[WIDTH-1];
         assign b_msb_d = b_eff[WIDTH-1];
`endif
      end else begin : g_next
         assign praw_d = stg[s-1].praw_q;
         assign c0_d   = stg[s-1].c0_q;
`ifdef PREFIX_ADDER_FLAGS_EN
         assign a_msb_d = stg[s-1].a_msb_q;
         assign b_msb_d = stg[s-1].b_msb_q;
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            gp_q   <= '0;
            praw_q <= '0;
            c0_q   <= 1'b0;
`ifdef PREFIX_ADDER_FLAGS_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
`endif
         end else if (load[s]) begin
            gp_q   <= lvl[LAST].gout;
            praw_q <= praw_d;
            c0_q   <= c0_d;
`ifdef PREFIX_ADDER_FLAGS_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
`endif
         end
      end

      if (s == S - 1) begin : g_tail
         assign fin_gp   = gp_q;
         assign fin_praw = praw_q;
         assign fin_c0   = c0_q;
`ifdef PREFIX_ADDER_FLAGS_EN
         assign fin_a_msb = a_msb_q;
         assign fin_b_msb = b_msb_q;
`endif
      end
   end

   // Level k reads the pre-processed operands, a stage register (first
   // level of a stage), or the previous level's combinational output.
   for (genvar k = 0; k < L; k++) begin : lvl
      localparam int SPAN = level_span(k);

      gp_t [WIDTH-1:0] gin;
      gp_t [WIDTH-1:0] gout;

      if (k == 0) begin : g_in_pre
         assign gin = gp_pre;
      end else if (k % LVL_PER_STG == 0) begin : g_in_reg
         assign gin = stg[k/LVL_PER_STG - 1].gp_q;
      end else begin : g_in_chain
         assign gin = lvl[k-1].gout;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : pos
         if (i >= SPAN) begin : g_node
            prefix_gp_node u_node (
               .cur  (gin[i]),
               .prev (gin[i-SPAN]),
               .res  (gout[i])
            );
         end else begin : g_pass
            assign gout[i] = gin[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         g_fin[i] = fin_gp[i].g;
         p_fin[i] = fin_gp[i].p;
      end
   end

   // Group propagate is not needed once every position has its full prefix.
   assign unused_p = ^p_fin;

   assign sum       = fin_praw ^ {g_fin[WIDTH-2:0], fin_c0};
   assign cout      = g_fin[WIDTH-1];
   assign out_valid = v[S-1];

`ifdef PREFIX_ADDER_FLAGS_EN
   assign ovf  = (fin_a_msb == fin_b_msb) & (sum[WIDTH-1] != fin_a_msb);
   // Gated by valid so the flag reads 0 out of reset rather than "sum is 0".
   assign zero = v[S-1] & ~|sum;
`endif

endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with a valid/ready handshake on both sides. It generalises the team's fixed 8-bit combinational prefix circuits to any power-of-two width, and adds carry-in, a subtract mode and configurable register placement between prefix levels. It sits in the arithmetic datapath, where it feeds accumulators and address generators that can apply backpressure.

## Interface
- `WIDTH`, default 32: operand width. Power of two, ≥ 4.
- `LVL_PER_STG`, default 2: prefix levels per pipeline stage, ≥ 1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts the beat this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in. Ignored when `sub`=1.
- `sub` in 1: 1 computes a − b, as a + ~b + 1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `sum` out WIDTH: result.
- `cout` out 1: carry-out of the MSB (for subtract, 1 means no borrow).
- `ovf` out 1: signed overflow. Present only with the macro.
- `zero` out 1: sum == 0. Present only with the macro.

## Operation
- L = clog2(WIDTH) prefix levels. S = ceil(L / LVL_PER_STG) register stages.
- Pre-processing happens combinationally before stage 0:
  - b' = sub ? ~b : b
  - c0 = sub ? 1 : cin
  - g_i = a_i & b'_i, p_i = a_i ^ b'_i
  - c0 is folded in as generate of position −1: g_0 |= p_0 & c0.
- Kogge-Stone level k combines position i with position i − 2^k when i ≥ 2^k. Otherwise (g, p) passes through unchanged.
- Stage boundaries fall after every LVL_PER_STG levels. Each stage register holds g[WIDTH], p[WIDTH], the raw p_i (needed for the sum), c0 and the flag-side MSB bits.
- The post-processing is the last stage's combinational tail:
  - sum_0 = p_0 ^ c0
  - sum_i = p_i ^ G_{i−1}
  - cout = G_{WIDTH−1}
- Stage n advances when its successor is empty or is advancing (bubble-collapsing). For the last stage, "advancing" means out_valid & out_ready.
- in_ready = ~v[0] | adv[0]. in_ready is combinational from out_ready through the valid chain. No other combinational path runs from inputs to outputs.
- Payload registers load only on acceptance. A stalled stage holds its contents unchanged.
- Reset: all stage valid bits are cleared, so out_valid=0; sum, cout, ovf and zero reset to 0. in_ready is 1 once rst_n is high.
- Reset asserted mid-operation discards all in-flight beats. No result is emitted for them.

## Timing
- Latency is S cycles from in_valid&in_ready to out_valid, with no stalls. Example: WIDTH=8, LVL_PER_STG=1 gives S=3.
- Throughput is 1 beat/cycle while out_ready=1.
- Capacity is S beats. With out_ready held 0, in_ready falls after S beats have been accepted.
- In the same cycle as an output handshake on a full pipeline, a new beat is accepted (in_ready=1).
- Outputs are stable while out_valid=1 and out_ready=0.

## Configuration
- `PREFIX_ADDER_FLAGS_EN` defined:
  - `ovf` = (a'_{MSB} == b'_{MSB}) & (sum_{MSB} != a_{MSB}), where b' is after inversion.
  - `zero` = ~|sum.
  - Both flags are registered alongside sum in the last stage.
- Macro undefined: the ports `ovf` and `zero` do not exist, and no flag logic or flag storage is generated.

## Structure
- Package `prefix_adder_pkg` contains:
  - the `gp_t` struct {g, p};
  - the function `num_stages(width, lvl_per_stg)`;
  - the localparam helpers for level spans (2^k).
- Sub-module `prefix_gp_node` is the combinational (G, P) combine:
  - G = Gi | Pi & Gprev
  - P = Pi & Pprev
- `prefix_gp_node` is instantiated per position per level through a generate loop.

## Test plan
All scenarios use WIDTH=8, LVL_PER_STG=1 (S=3) unless noted.
- 0xFF + 0x01, cin=0, sub=0 -> after 3 cycles sum=0x00, cout=1.
- 0x05 − 0x07 (sub=1, cin=1, where cin must be ignored) -> sum=0xFE, cout=0. Then 0x07 − 0x05 -> sum=0x02, cout=1.
- 20 back-to-back random beats with out_ready=1 -> 20 results in order, one per cycle, each matching a+b+cin against a reference model.
- Backpressure:
  - stimulus: out_ready=0 with continuous in_valid;
  - 3 beats are accepted, then in_ready=0;
  - out_ready is raised -> results drain in order, one beat accepted per drained beat, nothing lost or duplicated.
- Reset mid-operation: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, and no stale result after release.
- Flags, with the macro defined:
  - 0x7F + 0x01 -> ovf=1, zero=0;
  - 0x80 + 0x80 -> sum=0x00, cout=1, ovf=1, zero=1.
  - Repeat the random run with WIDTH=32, LVL_PER_STG=2.
